// File: rtl/ls_queue_pkg.sv
// Shared opcode encoding and memory-map constants for the load/store queue.
// Loads occupy the low opcode range; anything above OP_LHU is a store.
package ls_queue_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LH  = 4'd2,
        OP_LW  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } op_e;

    // Memory-mapped IO window; loads here have side effects and must wait for the ROB head.
    localparam logic [31:0] RAM_IO_ADDRESS = 32'h0003_0000;

    function automatic logic lsq_is_load(input op_e op);
        return op <= OP_LHU;
    endfunction

endpackage

// File: rtl/lsq_wakeup.sv
// CDB snoop for one queue slot: compares both source tags against every
// channel and selects the broadcast data. Lowest channel wins on duplicates.
module lsq_wakeup #(
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int CDB_N    = 2
) (
    input  logic [ROB_ID_W-1:0]       q1_i,
    input  logic [ROB_ID_W-1:0]       q2_i,
    input  logic [CDB_N-1:0]          cdb_valid_i,
    input  logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id_i,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data_i,
    output logic                      hit1_o,
    output logic [DATA_W-1:0]         data1_o,
    output logic                      hit2_o,
    output logic [DATA_W-1:0]         data2_o
);

    // Scan from the top channel down so the lowest matching channel is the last write.
    always_comb begin
        hit1_o  = 1'b0;
        data1_o = '0;
        hit2_o  = 1'b0;
        data2_o = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (cdb_valid_i[c] && q1_i != '0 && cdb_rob_id_i[c*ROB_ID_W +: ROB_ID_W] == q1_i) begin
                hit1_o  = 1'b1;
                data1_o = cdb_data_i[c*DATA_W +: DATA_W];
            end
            if (cdb_valid_i[c] && q2_i != '0 && cdb_rob_id_i[c*ROB_ID_W +: ROB_ID_W] == q2_i) begin
                hit2_o  = 1'b1;
                data2_o = cdb_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: circular buffer [head, tail) between dispatcher and LSU.
// Operands wake up from the CDBs, the head entry issues in program order, and a
// misbranch flush keeps only the committed stores that are contiguous from head.
// Optional: define LSQ_PERF_CNT_EN to add saturating load/store/stall counters.
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ROB_ID_W    = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int CDB_N       = 2,
    parameter int FULL_MARGIN = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rdy_i,
    input  logic                      disp_en_i,
    input  op_e                       disp_op_i,
    input  logic [ROB_ID_W-1:0]       disp_q1_i,
    input  logic [ROB_ID_W-1:0]       disp_q2_i,
    input  logic [DATA_W-1:0]         disp_v1_i,
    input  logic [DATA_W-1:0]         disp_v2_i,
    input  logic [DATA_W-1:0]         disp_imm_i,
    input  logic [ROB_ID_W-1:0]       disp_rob_id_i,
    input  logic [CDB_N-1:0]          cdb_valid_i,
    input  logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id_i,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data_i,
    input  logic                      commit_en_i,
    input  logic [ROB_ID_W-1:0]       commit_rob_id_i,
    input  logic [ROB_ID_W-1:0]       io_rob_id_in_i,
    output logic [ROB_ID_W-1:0]       io_rob_id_out_o,
    input  logic                      lsu_busy_i,
    output logic                      lsu_en_o,
    output op_e                       lsu_op_o,
    output logic [ADDR_W-1:0]         lsu_addr_o,
    output logic [DATA_W-1:0]         lsu_wdata_o,
    output logic                      full_o,
    input  logic                      misbranch_i
`ifdef LSQ_PERF_CNT_EN
    ,
    output logic [31:0]               perf_loads_o,
    output logic [31:0]               perf_stores_o,
    output logic [31:0]               perf_stall_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic [DEPTH-1:0]    vld_q, cmt_q;
    op_e                 op_q  [DEPTH];
    logic [ROB_ID_W-1:0] q1_q  [DEPTH];
    logic [ROB_ID_W-1:0] q2_q  [DEPTH];
    logic [DATA_W-1:0]   v1_q  [DEPTH];
    logic [DATA_W-1:0]   v2_q  [DEPTH];
    logic [DATA_W-1:0]   imm_q [DEPTH];
    logic [ROB_ID_W-1:0] rid_q [DEPTH];

    logic                lsu_en_q;
    op_e                 lsu_op_q;
    logic [ADDR_W-1:0]   lsu_addr_q;
    logic [DATA_W-1:0]   lsu_wdata_q;

    // Wakeup results
    logic [DEPTH-1:0]    wk_hit1, wk_hit2;
    logic [DATA_W-1:0]   wk_d1 [DEPTH];
    logic [DATA_W-1:0]   wk_d2 [DEPTH];
    logic                byp_hit1, byp_hit2;
    logic [DATA_W-1:0]   byp_d1, byp_d2;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wk
        lsq_wakeup #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) u_wk (
            .q1_i(q1_q[g]), .q2_i(q2_q[g]),
            .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i), .cdb_data_i(cdb_data_i),
            .hit1_o(wk_hit1[g]), .data1_o(wk_d1[g]), .hit2_o(wk_hit2[g]), .data2_o(wk_d2[g])
        );
    end

    // Dispatch bypass: operands broadcast in the same cycle as dispatch are captured directly.
    lsq_wakeup #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .CDB_N(CDB_N)) u_byp (
        .q1_i(disp_q1_i), .q2_i(disp_q2_i),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i), .cdb_data_i(cdb_data_i),
        .hit1_o(byp_hit1), .data1_o(byp_d1), .hit2_o(byp_hit2), .data2_o(byp_d2)
    );

    // Head decision
    logic              h_load, h_io, h_rdy, issue_ok, issue, disp;
    logic [DATA_W-1:0] h_sum;
    logic [ADDR_W-1:0] h_addr;
    logic [PTR_W-1:0]  head_nx;

    assign h_load   = lsq_is_load(op_q[head_q]);
    assign h_sum    = v1_q[head_q] + imm_q[head_q];
    assign h_addr   = ADDR_W'(h_sum);
    assign h_io     = (h_addr == ADDR_W'(RAM_IO_ADDRESS));
    assign h_rdy    = vld_q[head_q] && q1_q[head_q] == '0 && q2_q[head_q] == '0;
    assign issue_ok = h_rdy && !lsu_busy_i &&
                      (h_load ? (!h_io || io_rob_id_in_i == rid_q[head_q]) : cmt_q[head_q]);
    // A flush suppresses a speculative load; a committed store still goes out.
    assign issue    = issue_ok && (!misbranch_i || !h_load);
    assign disp     = disp_en_i && !misbranch_i;
    assign head_nx  = head_q + PTR_W'(issue);

    assign io_rob_id_out_o = (vld_q[head_q] && h_io) ? rid_q[head_q] : '0;
    assign full_o          = (count_q >= CNT_W'(DEPTH - FULL_MARGIN));

    // Commit bits including this cycle's commit, so the flush sees it.
    logic [DEPTH-1:0] cmt_nx;
    always_comb begin
        cmt_nx = cmt_q;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i] && commit_en_i && rid_q[i] == commit_rob_id_i) cmt_nx[i] = 1'b1;
    end

    // Flush survivors: committed stores running contiguously from the post-pop head.
    logic [DEPTH-1:0] keep;
    logic [CNT_W-1:0] kept;
    logic [PTR_W-1:0] fl_idx;
    logic             fl_run;
    always_comb begin
        keep   = '0;
        kept   = '0;
        fl_run = 1'b1;
        fl_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fl_idx = head_nx + PTR_W'(i);
            if (fl_run && vld_q[fl_idx] && !(issue && fl_idx == head_q) &&
                !lsq_is_load(op_q[fl_idx]) && cmt_nx[fl_idx]) begin
                keep[fl_idx] = 1'b1;
                kept         = kept + CNT_W'(1);
            end else begin
                fl_run = 1'b0;
            end
        end
    end

    // Next pointers, occupancy and valid bits.
    logic [DEPTH-1:0] vld_nx;
    logic [PTR_W-1:0] tail_nx;
    logic [CNT_W-1:0] count_nx;
    always_comb begin
        vld_nx = vld_q;
        if (issue) vld_nx[head_q] = 1'b0;
        if (misbranch_i) begin
            vld_nx   = keep;
            tail_nx  = head_nx + kept[PTR_W-1:0];
            count_nx = kept;
        end else begin
            if (disp) vld_nx[tail_q] = 1'b1;
            tail_nx  = tail_q + PTR_W'(disp);
            count_nx = count_q + CNT_W'(disp) - CNT_W'(issue);
        end
    end

    // Queue state update: wakeup and commit on every slot, then the dispatched entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            cmt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= OP_NOP;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                imm_q[i] <= '0;
                rid_q[i] <= '0;
            end
        end else if (rdy_i) begin
            head_q  <= head_nx;
            tail_q  <= tail_nx;
            count_q <= count_nx;
            vld_q   <= vld_nx;
            cmt_q   <= cmt_nx;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && wk_hit1[i]) begin
                    q1_q[i] <= '0;
                    v1_q[i] <= wk_d1[i];
                end
                if (vld_q[i] && wk_hit2[i]) begin
                    q2_q[i] <= '0;
                    v2_q[i] <= wk_d2[i];
                end
            end
            if (disp) begin
                op_q[tail_q]  <= disp_op_i;
                q1_q[tail_q]  <= byp_hit1 ? '0 : disp_q1_i;
                v1_q[tail_q]  <= byp_hit1 ? byp_d1 : disp_v1_i;
                q2_q[tail_q]  <= byp_hit2 ? '0 : disp_q2_i;
                v2_q[tail_q]  <= byp_hit2 ? byp_d2 : disp_v2_i;
                imm_q[tail_q] <= disp_imm_i;
                rid_q[tail_q] <= disp_rob_id_i;
                cmt_q[tail_q] <= 1'b0;
            end
        end
    end

    // Registered LSU request; lsu_en is a one-cycle pulse while rdy is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lsu_en_q    <= 1'b0;
            lsu_op_q    <= OP_NOP;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
        end else if (rdy_i) begin
            lsu_en_q <= issue;
            if (issue) begin
                lsu_op_q    <= op_q[head_q];
                lsu_addr_q  <= h_addr;
                lsu_wdata_q <= h_load ? '0 : v2_q[head_q];
            end
        end
    end

    assign lsu_en_o    = lsu_en_q;
    assign lsu_op_o    = lsu_op_q;
    assign lsu_addr_o  = lsu_addr_q;
    assign lsu_wdata_o = lsu_wdata_q;

`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_stall_q;

    // Saturating event counters; a stall is a valid head that did not issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_stall_q  <= '0;
        end else if (rdy_i) begin
            if (issue && h_load && perf_loads_q != '1)   perf_loads_q  <= perf_loads_q + 32'd1;
            if (issue && !h_load && perf_stores_q != '1) perf_stores_q <= perf_stores_q + 32'd1;
            if (vld_q[head_q] && !issue && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_loads_o  = perf_loads_q;
    assign perf_stores_o = perf_stores_q;
    assign perf_stall_o  = perf_stall_q;
`endif

    // Dispatching into a completely full queue is a dispatcher bug.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rdy_i && disp_en_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_ls_queue.sv
// Self-checking bench for ls_queue: directed scenarios plus a randomized phase
// checked against a queue-based reference model.
module tb_ls_queue;
    import ls_queue_pkg::*;

    localparam logic [31:0] IO_ADDR = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst_ni, rdy, disp_en, commit_en, lsu_busy, misbranch;
    op_e         disp_op;
    logic [3:0]  disp_q1, disp_q2, disp_rid, commit_rid, io_in;
    logic [31:0] disp_v1, disp_v2, disp_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rid;
    logic [63:0] cdb_data;
    logic [3:0]  io_out;
    logic        lsu_en, full;
    op_e         lsu_op;
    logic [31:0] lsu_addr, lsu_wdata;
`ifdef LSQ_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_stall;
`endif

    ls_queue dut (
        .clk_i(clk), .rst_ni(rst_ni), .rdy_i(rdy),
        .disp_en_i(disp_en), .disp_op_i(disp_op), .disp_q1_i(disp_q1), .disp_q2_i(disp_q2),
        .disp_v1_i(disp_v1), .disp_v2_i(disp_v2), .disp_imm_i(disp_imm), .disp_rob_id_i(disp_rid),
        .cdb_valid_i(cdb_valid), .cdb_rob_id_i(cdb_rid), .cdb_data_i(cdb_data),
        .commit_en_i(commit_en), .commit_rob_id_i(commit_rid),
        .io_rob_id_in_i(io_in), .io_rob_id_out_o(io_out),
        .lsu_busy_i(lsu_busy), .lsu_en_o(lsu_en), .lsu_op_o(lsu_op),
        .lsu_addr_o(lsu_addr), .lsu_wdata_o(lsu_wdata), .full_o(full),
        .misbranch_i(misbranch)
`ifdef LSQ_PERF_CNT_EN
        , .perf_loads_o(perf_loads), .perf_stores_o(perf_stores), .perf_stall_o(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: program-order list of in-flight entries.
    typedef struct {
        op_e         op;
        logic [3:0]  q1, q2, rid;
        logic [31:0] v1, v2, imm;
        bit          cmt;
    } ent_t;

    ent_t        mq[$];
    bit          m_en;
    op_e         m_op;
    logic [31:0] m_addr, m_wdata;

    function automatic void cdb_lookup(input logic [3:0] q, output bit hit, output logic [31:0] d);
        hit = 0;
        d   = '0;
        if (q != 0)
            for (int c = 0; c < 2; c++)
                if (!hit && cdb_valid[c] && cdb_rid[c*4 +: 4] == q) begin
                    hit = 1;
                    d   = cdb_data[c*32 +: 32];
                end
    endfunction

    function automatic logic [3:0] m_io();
        logic [31:0] a;
        if (mq.size() == 0) return 4'd0;
        a = mq[0].v1 + mq[0].imm;
        return (a == IO_ADDR) ? mq[0].rid : 4'd0;
    endfunction

    task automatic model_step();
        bit iss, ld, h;
        ent_t e, n;
        logic [31:0] a, d;
        int k;
        iss = 0; ld = 0; a = '0;
        if (mq.size() > 0) begin
            e  = mq[0];
            a  = e.v1 + e.imm;
            ld = (e.op <= OP_LHU);
            if (e.q1 == 0 && e.q2 == 0 && !lsu_busy)
                iss = ld ? (a != IO_ADDR || io_in == e.rid) : e.cmt;
            if (misbranch && ld) iss = 0;
        end
        m_en = iss;
        if (iss) begin
            m_op = e.op; m_addr = a; m_wdata = ld ? 32'd0 : e.v2;
        end
        foreach (mq[i]) begin
            if (commit_en && mq[i].rid == commit_rid) mq[i].cmt = 1;
            cdb_lookup(mq[i].q1, h, d);
            if (h) begin mq[i].q1 = 0; mq[i].v1 = d; end
            cdb_lookup(mq[i].q2, h, d);
            if (h) begin mq[i].q2 = 0; mq[i].v2 = d; end
        end
        if (iss) void'(mq.pop_front());
        if (misbranch) begin
            k = 0;
            while (k < mq.size() && mq[k].op > OP_LHU && mq[k].cmt) k++;
            while (mq.size() > k) void'(mq.pop_back());
        end else if (disp_en) begin
            n.op = disp_op; n.rid = disp_rid; n.imm = disp_imm; n.cmt = 0;
            cdb_lookup(disp_q1, h, d);
            n.q1 = h ? 4'd0 : disp_q1; n.v1 = h ? d : disp_v1;
            cdb_lookup(disp_q2, h, d);
            n.q2 = h ? 4'd0 : disp_q2; n.v2 = h ? d : disp_v2;
            mq.push_back(n);
        end
    endtask

    task automatic tick();
        if (rdy && rst_ni) model_step();
        @(posedge clk);
        #1;
        disp_en = 0; commit_en = 0; misbranch = 0; cdb_valid = '0;
    endtask

    task automatic set_disp(input op_e op, input logic [3:0] q1, input logic [3:0] q2,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [3:0] rid);
        disp_en = 1; disp_op = op; disp_q1 = q1; disp_q2 = q2;
        disp_v1 = v1; disp_v2 = v2; disp_imm = imm; disp_rid = rid;
    endtask

    task automatic test_reset();
        #3;
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL rst_en: got %b want 0", lsu_en); else n_pass++;
        n_tot++; if (lsu_op !== OP_NOP) $display("FAIL rst_op: got %0d want 0", lsu_op); else n_pass++;
        n_tot++; if (lsu_addr !== 32'd0 || lsu_wdata !== 32'd0)
            $display("FAIL rst_addr_wdata: got %h/%h want 0/0", lsu_addr, lsu_wdata); else n_pass++;
        n_tot++; if (full !== 1'b0 || io_out !== 4'd0)
            $display("FAIL rst_full_io: got %b/%0d want 0/0", full, io_out); else n_pass++;
        @(posedge clk); #1 rst_ni = 1;
        lsu_busy = 1;
        for (int i = 0; i < 5; i++) begin
            set_disp(OP_LW, 0, 0, 32'h100 + 32'(16 * i), 0, 0, 4'(i + 1));
            tick();
        end
        lsu_busy = 0;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h100)
            $display("FAIL midop_issue: got en=%b addr=%h want 1/100", lsu_en, lsu_addr); else n_pass++;
        #2 rst_ni = 0;
        #1;
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL async_rst_en: got %b want 0", lsu_en); else n_pass++;
        mq.delete(); m_en = 0; m_op = OP_NOP;
        @(posedge clk); #1;
        n_tot++; if (lsu_en !== 1'b0 || full !== 1'b0 || io_out !== 4'd0)
            $display("FAIL rst_edge: got en=%b full=%b io=%0d want 0/0/0", lsu_en, full, io_out); else n_pass++;
        rst_ni = 1;
        set_disp(OP_LW, 0, 0, 32'h40, 0, 0, 9);
        tick();
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h40)
            $display("FAIL rst_empty_head: got en=%b addr=%h want 1/40", lsu_en, lsu_addr); else n_pass++;
        tick();
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL rst_drained: got %b want 0", lsu_en); else n_pass++;
    endtask

    task automatic test_bypass();
        cdb_valid = 2'b10; cdb_rid = {4'd3, 4'd0}; cdb_data = {32'h1000, 32'h0};
        set_disp(OP_LW, 3, 0, 32'hBAD, 32'h77, 4, 2);
        tick();
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL byp_lat: got %b want 0", lsu_en); else n_pass++;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h1004 || lsu_wdata !== 32'd0 || lsu_op !== OP_LW)
            $display("FAIL byp_issue: got en=%b addr=%h wd=%h op=%0d want 1/1004/0/3",
                     lsu_en, lsu_addr, lsu_wdata, lsu_op); else n_pass++;
        cdb_valid = 2'b11; cdb_rid = {4'd3, 4'd3}; cdb_data = {32'h2000, 32'h500};
        set_disp(OP_LB, 3, 0, 0, 0, 0, 4);
        tick(); tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h500)
            $display("FAIL byp_lowest_ch: got en=%b addr=%h want 1/500", lsu_en, lsu_addr); else n_pass++;
        set_disp(OP_LH, 7, 0, 0, 0, 2, 5);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b0) $display("FAIL wake_wait%0d: got %b want 0", i, lsu_en); else n_pass++;
        end
        cdb_valid = 2'b01; cdb_rid = {4'd0, 4'd7}; cdb_data = {32'h0, 32'h800};
        tick();
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL wake_lat: got %b want 0", lsu_en); else n_pass++;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h802)
            $display("FAIL wake_issue: got en=%b addr=%h want 1/802", lsu_en, lsu_addr); else n_pass++;
        tick();
    endtask

    task automatic test_commit();
        cdb_valid = 2'b10; cdb_rid = {4'd9, 4'd0}; cdb_data = {32'hDEAD_BEEF, 32'h0};
        set_disp(OP_SW, 0, 9, 32'h200, 32'h0, 8, 6);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin commit_en = 1; commit_rid = 11; end
            tick();
            n_tot++; if (lsu_en !== 1'b0) $display("FAIL sw_uncommitted%0d: got %b want 0", i, lsu_en); else n_pass++;
        end
        commit_en = 1; commit_rid = 6;
        tick();
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL sw_commit_lat: got %b want 0", lsu_en); else n_pass++;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h208 || lsu_wdata !== 32'hDEAD_BEEF || lsu_op !== OP_SW)
            $display("FAIL sw_issue: got en=%b addr=%h wd=%h op=%0d want 1/208/deadbeef/8",
                     lsu_en, lsu_addr, lsu_wdata, lsu_op); else n_pass++;
        tick();
    endtask

    task automatic test_io();
        io_in = 2;
        set_disp(OP_LW, 0, 0, 32'h0002_FFFC, 0, 4, 7);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b0 || io_out !== 4'd7)
                $display("FAIL io_stall%0d: got en=%b io=%0d want 0/7", i, lsu_en, io_out); else n_pass++;
        end
        io_in = 7;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== IO_ADDR)
            $display("FAIL io_issue: got en=%b addr=%h want 1/30000", lsu_en, lsu_addr); else n_pass++;
        n_tot++; if (io_out !== 4'd0) $display("FAIL io_empty: got %0d want 0", io_out); else n_pass++;
        io_in = 0;
        tick();
    endtask

    task automatic test_freeze();
        set_disp(OP_LW, 0, 0, 32'h600, 0, 0, 11);
        tick(); tick();
        rdy = 0;
        set_disp(OP_LW, 0, 0, 32'h700, 0, 0, 12);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h600)
                $display("FAIL freeze_hold%0d: got en=%b addr=%h want 1/600", i, lsu_en, lsu_addr); else n_pass++;
        end
        rdy = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b0) $display("FAIL freeze_nodisp%0d: got %b want 0", i, lsu_en); else n_pass++;
        end
    endtask

    task automatic test_full_wrap();
        int ndisp, cyc;
        logic [3:0] rid;
        lsu_busy = 1;
        for (int i = 1; i <= 13; i++) begin
            set_disp(OP_LW, 0, 0, 32'h1000 + 32'(4 * i), 0, 0, 4'(i));
            tick();
            n_tot++; if (full !== (i >= 13)) $display("FAIL full_at%0d: got %b want %b", i, full, i >= 13); else n_pass++;
        end
        lsu_busy = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_tot++; if (lsu_en !== m_en || (m_en && lsu_addr !== m_addr))
                $display("FAIL drain%0d: got en=%b addr=%h want %b/%h", i, lsu_en, lsu_addr, m_en, m_addr); else n_pass++;
        end
        ndisp = 0; cyc = 0; rid = 1;
        while ((ndisp < 40 || cyc < 200) && cyc < 2000) begin
            lsu_busy = ($urandom_range(0, 3) == 0);
            if (mq.size() < 13 && $urandom_range(0, 1) == 1) begin
                set_disp(op_e'($urandom_range(1, 8)),
                         ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                         ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                         32'($urandom_range(0, 16'hFFFF)), $urandom, 32'($urandom_range(0, 255)), rid);
                rid = (rid == 4'd15) ? 4'd1 : rid + 4'd1;
                ndisp++;
            end
            for (int c = 0; c < 2; c++) begin
                cdb_valid[c]        = ($urandom_range(0, 9) < 4);
                cdb_rid[c*4 +: 4]   = 4'($urandom_range(1, 15));
                cdb_data[c*32 +: 32] = 32'($urandom_range(0, 16'hFFFF));
            end
            if (mq.size() > 0 && $urandom_range(0, 9) < 3) begin
                commit_en = 1; commit_rid = mq[$urandom_range(0, mq.size() - 1)].rid;
            end
            misbranch = ($urandom_range(0, 39) == 0);
            tick();
            cyc++;
            n_tot++; if (lsu_en !== m_en || (m_en && (lsu_addr !== m_addr || lsu_wdata !== m_wdata || lsu_op !== m_op)))
                $display("FAIL rand_issue@%0d: got en=%b op=%0d addr=%h wd=%h want %b/%0d/%h/%h",
                         cyc, lsu_en, lsu_op, lsu_addr, lsu_wdata, m_en, m_op, m_addr, m_wdata); else n_pass++;
            n_tot++; if (full !== (mq.size() >= 13) || io_out !== m_io())
                $display("FAIL rand_flags@%0d: got full=%b io=%0d want %b/%0d",
                         cyc, full, io_out, mq.size() >= 13, m_io()); else n_pass++;
        end
        n_tot++; if (ndisp < 40) $display("FAIL wrap_volume: got %0d dispatches want >=40", ndisp); else n_pass++;
        misbranch = 1; lsu_busy = 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            cdb_valid = 2'b01; cdb_rid = {4'd0, 4'(i % 15 + 1)}; cdb_data = {32'h0, 32'h0000_0100};
            tick();
            n_tot++; if (lsu_en !== m_en || (m_en && (lsu_addr !== m_addr || lsu_wdata !== m_wdata)))
                $display("FAIL final_drain%0d: got en=%b addr=%h wd=%h want %b/%h/%h",
                         i, lsu_en, lsu_addr, lsu_wdata, m_en, m_addr, m_wdata); else n_pass++;
        end
        n_tot++; if (full !== 1'b0 || io_out !== 4'd0)
            $display("FAIL drained_flags: got full=%b io=%0d want 0/0", full, io_out); else n_pass++;
    endtask

    task automatic test_misbranch();
        lsu_busy = 1;
        set_disp(OP_SW, 0, 0, 32'h400, 32'h11, 0, 1);
        tick();
        set_disp(OP_SW, 0, 0, 32'h404, 32'h22, 0, 2);
        commit_en = 1; commit_rid = 1;
        tick();
        commit_en = 1; commit_rid = 2;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_LW, 0, 0, 32'h500 + 32'(4 * i), 0, 0, 4'(3 + i));
            tick();
        end
        misbranch = 1;
        set_disp(OP_LW, 0, 0, 32'h900, 0, 0, 6);
        tick();
        lsu_busy = 0;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h400 || lsu_wdata !== 32'h11)
            $display("FAIL mb_sw0: got en=%b addr=%h wd=%h want 1/400/11", lsu_en, lsu_addr, lsu_wdata); else n_pass++;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h404 || lsu_wdata !== 32'h22)
            $display("FAIL mb_sw1: got en=%b addr=%h wd=%h want 1/404/22", lsu_en, lsu_addr, lsu_wdata); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b0) $display("FAIL mb_dropped%0d: got %b want 0", i, lsu_en); else n_pass++;
        end
        // Commit arriving with the flush keeps the store.
        lsu_busy = 1;
        set_disp(OP_SW, 0, 0, 32'h440, 32'h33, 0, 7);
        tick();
        set_disp(OP_LW, 0, 0, 32'h480, 0, 0, 8);
        tick();
        lsu_busy = 0; commit_en = 1; commit_rid = 7; misbranch = 1;
        tick();
        n_tot++; if (lsu_en !== 1'b0) $display("FAIL mb_commit_lat: got %b want 0", lsu_en); else n_pass++;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h440 || lsu_wdata !== 32'h33)
            $display("FAIL mb_samecyc_commit: got en=%b addr=%h wd=%h want 1/440/33", lsu_en, lsu_addr, lsu_wdata); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b0) $display("FAIL mb_load_gone%0d: got %b want 0", i, lsu_en); else n_pass++;
        end
        // Committed store issuing in the flush cycle still goes out.
        lsu_busy = 1;
        set_disp(OP_SH, 0, 0, 32'h4C0, 32'h44, 0, 9);
        tick();
        set_disp(OP_LW, 0, 0, 32'h4C4, 0, 0, 10);
        commit_en = 1; commit_rid = 9;
        tick();
        lsu_busy = 0; misbranch = 1;
        tick();
        n_tot++; if (lsu_en !== 1'b1 || lsu_addr !== 32'h4C0 || lsu_op !== OP_SH)
            $display("FAIL mb_pop_store: got en=%b addr=%h op=%0d want 1/4c0/7", lsu_en, lsu_addr, lsu_op); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tot++; if (lsu_en !== 1'b0 || full !== 1'b0)
                $display("FAIL mb_pop_after%0d: got en=%b full=%b want 0/0", i, lsu_en, full); else n_pass++;
        end
    endtask

    initial begin
        rst_ni = 0; rdy = 1; disp_en = 0; disp_op = OP_NOP; disp_q1 = 0; disp_q2 = 0;
        disp_v1 = 0; disp_v2 = 0; disp_imm = 0; disp_rid = 0;
        cdb_valid = 0; cdb_rid = 0; cdb_data = 0; commit_en = 0; commit_rid = 0;
        io_in = 0; lsu_busy = 0; misbranch = 0;
        m_en = 0; m_op = OP_NOP; m_addr = 0; m_wdata = 0;
        test_reset();
        test_bypass();
        test_commit();
        test_io();
        test_freeze();
        test_full_wrap();
        test_misbranch();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
